// File: rtl/div_unit_pkg.sv
// Shared types and constants for the iterative div/divu unit and its ID/EX users.
package div_unit_pkg;

  localparam int unsigned WIDTH  = 32;
  localparam int unsigned CNT_W  = 6;
  localparam int unsigned RES_W  = 2 * WIDTH;
  localparam int unsigned WORK_W = 2 * WIDTH + 1;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;

  // ALU op and SPECIAL function codes used by the ID decode
  localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;
  localparam logic [5:0] EXE_DIV     = 6'b01_1010;
  localparam logic [5:0] EXE_DIVU    = 6'b01_1011;

  typedef struct packed {
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quot;
  } div_result_t;

  // Magnitude of an operand; only negative values of signed ops are complemented
  function automatic logic [WIDTH-1:0] abs_val(input logic is_signed, input logic [WIDTH-1:0] v);
    return (is_signed && v[WIDTH-1]) ? WIDTH'(-v) : v;
  endfunction

endpackage

// File: rtl/div_unit_if.sv
// EX <-> divider handshake: operands and start/annul in, {remainder, quotient} and ready out.
interface div_unit_if;
  import div_unit_pkg::*;

  logic              signed_div_i;
  logic [WIDTH-1:0]  opdata1_i;
  logic [WIDTH-1:0]  opdata2_i;
  logic              start_i;
  logic              annul_i;
  div_result_t       result_o;
  logic              ready_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o
  );
endinterface

// File: rtl/div_unit.sv
// Radix-2 restoring divider, one quotient bit per clock, for div/divu.
// Result is {remainder, quotient}, held while EX keeps start_i asserted.
module div_unit
  import div_unit_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  div_unit_if.slave  bus
);

  div_state_e        state_q, state_n;
  logic [CNT_W-1:0]  cnt_q, cnt_n;
  logic [WORK_W-1:0] work_q, work_n;
  logic [WIDTH-1:0]  divisor_q, divisor_n;
  logic              signed_q, signed_n;
  logic              sign1_q, sign1_n;
  logic              sign2_q, sign2_n;
  div_result_t       result_q, result_n;
  logic              ready_q, ready_n;

  logic [WIDTH:0]    diff;
  logic [WIDTH-1:0]  quot_fix;
  logic [WIDTH-1:0]  rem_fix;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= DivFree;
      cnt_q     <= '0;
      work_q    <= '0;
      divisor_q <= '0;
      signed_q  <= 1'b0;
      sign1_q   <= 1'b0;
      sign2_q   <= 1'b0;
      result_q  <= '0;
      ready_q   <= DivResultNotReady;
    end else begin
      state_q   <= state_n;
      cnt_q     <= cnt_n;
      work_q    <= work_n;
      divisor_q <= divisor_n;
      signed_q  <= signed_n;
      sign1_q   <= sign1_n;
      sign2_q   <= sign2_n;
      result_q  <= result_n;
      ready_q   <= ready_n;
    end
  end

  always_comb begin
    state_n   = state_q;
    cnt_n     = cnt_q;
    work_n    = work_q;
    divisor_n = divisor_q;
    signed_n  = signed_q;
    sign1_n   = sign1_q;
    sign2_n   = sign2_q;
    result_n  = result_q;
    ready_n   = ready_q;

    // Trial subtraction of the divisor from the upper partial remainder
    diff     = work_q[WORK_W-1:WIDTH] - {1'b0, divisor_q};
    quot_fix = (signed_q && (sign1_q ^ sign2_q)) ? WIDTH'(-work_q[WIDTH-1:0])
                                                 : work_q[WIDTH-1:0];
    rem_fix  = (signed_q && sign1_q) ? WIDTH'(-work_q[WORK_W-1:WIDTH+1])
                                     : work_q[WORK_W-1:WIDTH+1];

    case (state_q)
      DivFree: begin
        ready_n  = DivResultNotReady;
        result_n = '0;
        if (bus.start_i == DivStart && !bus.annul_i) begin
          if (bus.opdata2_i == '0) begin
            state_n = DivByZero;
          end else begin
            state_n   = DivOn;
            cnt_n     = '0;
            work_n    = {WIDTH'(0), abs_val(bus.signed_div_i, bus.opdata1_i), 1'b0};
            divisor_n = abs_val(bus.signed_div_i, bus.opdata2_i);
            signed_n  = bus.signed_div_i;
            sign1_n   = bus.opdata1_i[WIDTH-1];
            sign2_n   = bus.opdata2_i[WIDTH-1];
          end
        end
      end

      DivByZero: begin
        work_n   = '0;
        ready_n  = DivResultNotReady;
        result_n = '0;
        state_n  = DivEnd;
      end

      DivOn: begin
        if (bus.annul_i) begin
          state_n = DivFree;
          cnt_n   = '0;
        end else if (cnt_q == CNT_W'(WIDTH)) begin
          state_n  = DivEnd;
          cnt_n    = '0;
          result_n = '{rem: rem_fix, quot: quot_fix};
          ready_n  = DivResultReady;
        end else begin
          if (diff[WIDTH]) begin
            work_n = {work_q[WORK_W-2:0], 1'b0};
          end else begin
            work_n = {diff[WIDTH-1:0], work_q[WIDTH-1:0], 1'b1};
          end
          cnt_n = cnt_q + CNT_W'(1);
        end
      end

      DivEnd: begin
        // Hold the result until EX releases start_i; annul has no effect here
        if (bus.start_i == DivStop) begin
          state_n  = DivFree;
          ready_n  = DivResultNotReady;
          result_n = '0;
        end else begin
          ready_n = DivResultReady;
        end
      end

      default: begin
        state_n  = DivFree;
        ready_n  = DivResultNotReady;
        result_n = '0;
      end
    endcase
  end

  assign bus.result_o = result_q;
  assign bus.ready_o  = ready_q;

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative radix-2 restoring divider, 32 iterations, for the div/divu instructions.
- EX owns the handshake: it raises start_i for a div op decoded by ID and stalls the pipeline until ready_o.
- On ready_o, EX writes result_o into HI/LO: HI = remainder, LO = quotient.
- Sits beside EX, one stage downstream of ID; consumes the EX-forwarded source operands reg1/reg2.

Parameters:
- WIDTH, 32, operand width. The result is 2*WIDTH bits.
- CNT_W, 6, iteration-counter width. Must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  reset, asynchronous, active-low.
- signed_div_i  in  1  1 = signed div, 0 = divu. Sampled at the start edge.
- opdata1_i  in  WIDTH  dividend (rs). Sampled at the start edge.
- opdata2_i  in  WIDTH  divisor (rt). Sampled at the start edge.
- start_i  in  1  request. Held high by EX until it has consumed ready_o.
- annul_i  in  1  abort, e.g. a pipeline flush.
- result_o  out  2*WIDTH  {remainder, quotient}. Registered.
- ready_o  out  1  result valid. Registered.

Behaviour:
- Reset (rst=0, asynchronous): state=DIV_FREE, cnt=0, dividend register=0, result_o=0, ready_o=0.
- Outputs are driven only from registers; there is no combinational path from inputs to outputs.

States: DIV_FREE, DIV_BY_ZERO, DIV_ON, DIV_END. Encoding is 2 bits, defined in defines.v.

DIV_FREE:
- Condition: start_i=1 and annul_i=0.
- If opdata2_i==0: go to DIV_BY_ZERO.
- Otherwise go to DIV_ON, cnt=0, and latch the operands:
  - For signed ops, each operand with bit31=1 is replaced by its two's complement.
  - Latch the magnitudes, signed_div_i, and both original sign bits.
  - Working register = {WIDTH zeros, |dividend|, 1'b0}, 2*WIDTH+1 bits.
- ready_o=0 and result_o=0 throughout this state.

DIV_BY_ZERO:
- Go to DIV_END unconditionally on the next edge, with quotient=0 and remainder=0.

DIV_ON, one iteration per edge while annul_i=0:
- diff = working[2*WIDTH:WIDTH] - {1'b0, |divisor|}.
- If diff is negative: working <= {working[2*WIDTH-1:0], 1'b0}.
- Otherwise: working <= {diff[WIDTH-1:0], working[WIDTH-1:0], 1'b1}.
- cnt increments each iteration.
- At the edge where cnt==WIDTH: no iteration. Go to DIV_END and apply the sign fix-up:
  - quotient = working[WIDTH-1:0], negated if signed and the sign bits differ.
  - remainder = working[2*WIDTH:WIDTH+1], negated if signed and the dividend was negative.
  - result_o <= {remainder, quotient}, ready_o <= 1, cnt <= 0.
- annul_i=1 in DIV_ON: go to DIV_FREE on the next edge. result_o and ready_o stay 0 and no result is produced.

Latency:
- Start edge E0 (state leaves DIV_FREE).
- Iterations occur on E1..E32.
- ready_o is first high after E33.
- Divide by zero: ready_o is first high after E2.

DIV_END:
- ready_o=1 and result_o are held stable while start_i=1.
- When start_i=0: go to DIV_FREE, ready_o <= 0, result_o <= 0.
- annul_i is ignored in DIV_END.

Boundary conditions:
- Signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0. This is a two's-complement wrap, not a trap.
- A change in opdata1_i or opdata2_i after E0 has no effect.
- start_i dropping during DIV_ON does not abort the operation; only annul_i aborts.
- Simultaneous start_i and annul_i in DIV_FREE: the divider stays in DIV_FREE.
- Reset mid-operation returns to the reset values immediately.

Decomposition:
- defines.v gains:
  - state codes DivFree, DivByZero, DivOn, DivEnd;
  - DivResultReady / DivResultNotReady;
  - DivStart / DivStop;
  - the EXE_DIV_OP / EXE_DIVU_OP aluop codes and the EXE_DIV / EXE_DIVU function codes for the ID decode.
- Single module, no sub-module. The one-iteration subtractor is inline logic.

Test Plan:
- Unsigned divu: 100 / 7, start held high. Required: ready_o first high after E33, result_o = {32'd2, 32'd14}. Then drop start_i: ready_o=0 and state DIV_FREE on the next edge.
- Signed div: 0xFFFFFFF9 / 2 (-7/2). Required: result_o = {0xFFFFFFFF, 0xFFFFFFFD}.
- Signed div: 7 / -2. Required: {0x00000001, 0xFFFFFFFD}.
- Signed div: 0x80000000 / -1. Required: {0, 0x80000000}.
- Divide by zero: 5 / 0. Required: ready_o high after E2, result_o=0. Hold start_i 10 cycles: output stable throughout.
- Annul: pulse annul_i at iteration 10. Required: DIV_FREE next edge, ready_o never rises. An immediate new start of 9 / 3 then returns {0, 3} after 33 edges.
- Reset: assert rst=0 asynchronously mid-DIV_ON. Required: outputs 0 immediately, before the next clock edge. After release, a new divide completes normally.
